// File: rtl/madd_err_sweep_pkg.sv
//==============================================================================
// Module : madd_eval_pkg
// Brief  : Shared sizes, FSM encoding and exact multiply-add golden model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package madd_eval_pkg;

    localparam int N_IN      = 6;
    localparam int N_OUT     = 4;
    localparam int ET        = 5;
    localparam int SWEEP_LEN = 2 ** N_IN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // a={in1,in0}, b={in3,in2}, c={in5,in4}; a*b+c peaks at 12, so N_OUT bits never overflow
    function automatic logic [N_OUT-1:0] madd_exact(input logic [N_IN-1:0] vec);
        logic [N_OUT-1:0] a;
        logic [N_OUT-1:0] b;
        logic [N_OUT-1:0] c;
        a = N_OUT'(vec[1:0]);
        b = N_OUT'(vec[3:2]);
        c = N_OUT'(vec[5:4]);
        return a * b + c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/madd_err_sweep_if.sv
//==============================================================================
// Module : madd_err_sweep_if
// Brief  : Control, DUT-drive and result bundle of the error-sweep harness.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface madd_err_sweep_if #(
    parameter int SUM_W = 10
);
    import madd_eval_pkg::*;

    logic              start;
    logic [N_IN-1:0]   vec_o;
    logic [N_OUT-1:0]  approx_i;
    logic              busy;
    logic              done;
    logic [N_OUT-1:0]  max_err;
    logic [SUM_W-1:0]  err_sum;
    logic [N_IN:0]     viol_cnt;
    logic              pass;

    modport master (
        input  start, approx_i,
        output vec_o, busy, done, max_err, err_sum, viol_cnt, pass
    );

    modport slave (
        output start, approx_i,
        input  vec_o, busy, done, max_err, err_sum, viol_cnt, pass
    );

endinterface

`default_nettype wire

// File: rtl/madd_err_acc.sv
//==============================================================================
// Module : madd_err_acc
// Brief  : Two-stage sample pipeline: register, abs-diff, max/sum/violation accumulate.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module madd_err_acc
    import madd_eval_pkg::*;
#(
    parameter int SUM_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [N_OUT-1:0]  exact,
    input  logic [N_OUT-1:0]  approx,
    output logic [N_OUT-1:0]  max_err,
    output logic [SUM_W-1:0]  err_sum,
    output logic [N_IN:0]     viol_cnt
);

    logic              s1_valid;
    logic [N_OUT-1:0]  s1_exact;
    logic [N_OUT-1:0]  s1_approx;
    logic [N_OUT-1:0]  err;
    logic [SUM_W:0]    sum_wide;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_exact  <= '0;
            s1_approx <= '0;
        end else begin
            s1_valid  <= in_valid;
            s1_exact  <= exact;
            s1_approx <= approx;
        end
    end

    always_comb begin
        err      = (s1_exact >= s1_approx) ? (s1_exact - s1_approx) : (s1_approx - s1_exact);
        sum_wide = {1'b0, err_sum} + (SUM_W+1)'(err);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            max_err  <= '0;
            err_sum  <= '0;
            viol_cnt <= '0;
        end else if (s1_valid) begin
            if (err > max_err)
                max_err <= err;
            // saturate instead of wrapping when the carry bit is set
            err_sum <= sum_wide[SUM_W] ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
            if (err > N_OUT'(ET))
                viol_cnt <= viol_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/madd_err_sweep.sv
//==============================================================================
// Module : madd_err_sweep
// Brief  : Sweeps all input vectors through an approximate madd and grades it.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module madd_err_sweep
    import madd_eval_pkg::*;
#(
    parameter int DUT_LAT = 0,
    parameter int SUM_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    madd_err_sweep_if.master  bus
);

    // DUT_LAT+2 drain cycles land done exactly SWEEP_LEN+DUT_LAT+3 cycles after start
    localparam int              DRAIN_CYC = DUT_LAT + 2;
    localparam int              DC_W      = $clog2(DRAIN_CYC + 1);
    localparam logic [N_IN-1:0] LAST_VEC  = N_IN'(SWEEP_LEN - 1);

    state_t            state;
    state_t            state_nxt;
    logic [N_IN-1:0]   vec;
    logic [DC_W-1:0]   drain_cnt;
    logic              pass_q;
    logic              accept;
    logic              sweeping;
    logic              smp_valid;
    logic [N_IN-1:0]   smp_vec;
    logic [N_OUT-1:0]  smp_exact;
    logic [N_OUT-1:0]  max_err;
    logic [SUM_W-1:0]  err_sum;
    logic [N_IN:0]     viol_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SWEEP;
            SWEEP:   if (vec == LAST_VEC) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DC_W'(DRAIN_CYC - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept   = 1'b0;
        sweeping = 1'b0;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            IDLE:    accept = bus.start;
            SWEEP: begin
                sweeping = 1'b1;
                bus.busy = 1'b1;
            end
            DRAIN:   bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec       <= '0;
            drain_cnt <= '0;
            pass_q    <= 1'b0;
        end else begin
            if (accept) begin
                vec    <= '0;
                pass_q <= 1'b0;
            end else if (sweeping && vec != LAST_VEC) begin
                vec <= vec + 1'b1;
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
            if (state == DRAIN && state_nxt == DONE)
                pass_q <= (viol_cnt == '0);
        end
    end

    // Vector/valid delay line aligns each vector with the DUT result it produced
    generate
        if (DUT_LAT == 0) begin : g_no_delay
            assign smp_vec   = vec;
            assign smp_valid = sweeping;
        end else begin : g_delay
            logic [DUT_LAT-1:0][N_IN:0] dly;
            always_ff @(posedge clk) begin
                if (rst) begin
                    dly <= '0;
                end else begin
                    dly[0] <= {sweeping, vec};
                    for (int k = 1; k < DUT_LAT; k++)
                        dly[k] <= dly[k-1];
                end
            end
            assign {smp_valid, smp_vec} = dly[DUT_LAT-1];
        end
    endgenerate

    assign smp_exact = madd_exact(smp_vec);

    madd_err_acc #(
        .SUM_W (SUM_W)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .in_valid (smp_valid),
        .exact    (smp_exact),
        .approx   (bus.approx_i),
        .max_err  (max_err),
        .err_sum  (err_sum),
        .viol_cnt (viol_cnt)
    );

    assign bus.vec_o    = vec;
    assign bus.max_err  = max_err;
    assign bus.err_sum  = err_sum;
    assign bus.viol_cnt = viol_cnt;
    assign bus.pass     = pass_q;

endmodule

`default_nettype wire
